alu_issue_stage: RTL and testbench

Registered issue/capture stage wrapped around the combinational 16-bit ALU. Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO. Drives the FIFO head onto the ALU inputs, captures the 17-bit ALU result into an output register, and presents it downstream with its tag over a second valid/ready interface. The ALU itself is instantiated by the parent; this block connects to its `in1`/`in2`/`operation` inputs and its `out` output.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_cmd_fifo.sv | 44 ++++
 rtl/alu_issue_stage.sv | 127 ++++++++++++
 tb/tb_alu_issue_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/capture stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    localparam int ALU_DW = 16;  // operand width
    localparam int ALU_RW = 17;  // result width (carry/borrow in bit 16)

    // Opcode is kept as a plain 3-bit vector so illegal codes 5..7 can be
    // stored and forwarded unchanged to the ALU.
    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD     = 3'd0;
    localparam alu_op_t ALU_SUB     = 3'd1;
    localparam alu_op_t ALU_AND     = 3'd2;
    localparam alu_op_t ALU_OR      = 3'd3;
    localparam alu_op_t ALU_XOR     = 3'd4;
    localparam alu_op_t ALU_OP_LAST = 3'd4;
    localparam alu_op_t ALU_OP_IDLE = 3'd7;  // driven while nothing is queued

    // FIFO entry minus the user tag (tag width is a module parameter).
    typedef struct packed {
        logic [ALU_DW-1:0] in1;
        logic [ALU_DW-1:0] in2;
        alu_op_t           op;
    } alu_cmd_t;

    function automatic logic alu_op_illegal(input alu_op_t op);
        return op > ALU_OP_LAST;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries, combinational head read.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: caller must not push when full_o or pop when empty_o.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]  wptr_q, rptr_q;
    logic [W-1:0] mem_q [DEPTH];

    // Pointer update; reset flushes all queued entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/capture stage around an external combinational 16-bit ALU.
// Latency: accept at edge N (empty FIFO, empty result reg) -> res_valid after N+1.
// Backpressure: res_ready low holds the result; FIFO absorbs DEPTH more, then cmd_ready drops.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [15:0]       cmd_in1,
    input  logic [15:0]       cmd_in2,
    input  logic [2:0]        cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [15:0]       alu_in1,
    output logic [15:0]       alu_in2,
    output logic [2:0]        alu_operation,
    input  logic [16:0]       alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [16:0]       res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_illegal,
    output logic [15:0]       issued_cnt
);
    localparam int CW = $bits(alu_cmd_t);
    localparam int EW = CW + TAG_W;

    typedef enum logic {RES_EMPTY = 1'b0, RES_FULL = 1'b1} res_state_t;

    res_state_t       state_q, state_d;
    logic             rst_done_q;
    logic [EW-1:0]    head;
    alu_cmd_t         head_cmd;
    logic [TAG_W-1:0] head_tag;
    alu_cmd_t         push_cmd;
    logic             fifo_full, fifo_empty;
    logic             push, cap;
    logic [16:0]      res_data_q;
    logic [TAG_W-1:0] res_tag_q;
    logic             res_illegal_q;
    logic [15:0]      issued_cnt_q;

    assign push_cmd = '{in1: cmd_in1, in2: cmd_in2, op: cmd_op};
    assign push     = cmd_valid & cmd_ready;
    assign cap      = !fifo_empty & (!res_valid | res_ready);

    alu_cmd_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({cmd_tag, push_cmd}),
        .pop_i   (cap),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_cmd = alu_cmd_t'(head[CW-1:0]);
    assign head_tag = head[EW-1 -: TAG_W];

    // Holds cmd_ready low during reset and releases it the cycle after.
    always_ff @(posedge clk) begin
        if (rst) rst_done_q <= 1'b0;
        else     rst_done_q <= 1'b1;
    end

    // Registered-state only: no path from res_ready or cmd_valid.
    assign cmd_ready = rst_done_q & !fifo_full;

    // Present the FIFO head to the ALU, or a harmless idle command.
    always_comb begin
        alu_in1       = '0;
        alu_in2       = '0;
        alu_operation = ALU_OP_IDLE;
        if (!fifo_empty) begin
            alu_in1       = head_cmd.in1;
            alu_in2       = head_cmd.in2;
            alu_operation = head_cmd.op;
        end
    end

    // Result-register state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RES_EMPTY;
        else     state_q <= state_d;
    end

    // Result-register next state: fill on capture, empty on drain without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RES_EMPTY: if (cap) state_d = RES_FULL;
            RES_FULL:  if (res_ready && !cap) state_d = RES_EMPTY;
            default:   state_d = RES_EMPTY;
        endcase
    end

    // Result-register outputs.
    always_comb begin
        res_valid = (state_q == RES_FULL);
    end

    // Capture the ALU result, tag and illegal flag; count every capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_q    <= '0;
            res_tag_q     <= '0;
            res_illegal_q <= 1'b0;
            issued_cnt_q  <= '0;
        end else if (cap) begin
            res_data_q    <= alu_out;
            res_tag_q     <= head_tag;
            res_illegal_q <= alu_op_illegal(head_cmd.op);
            issued_cnt_q  <= issued_cnt_q + 16'd1;
        end
    end

    assign res_data    = res_data_q;
    assign res_tag     = res_tag_q;
    assign res_illegal = res_illegal_q;
    assign issued_cnt  = issued_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU attached.
// Latency: n/a.
// Backpressure: exercised by directed sequences below.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_in1 = '0;
    logic [15:0] cmd_in2 = '0;
    logic [2:0]  cmd_op = '0;
    logic [3:0]  cmd_tag = '0;
    logic [15:0] alu_in1, alu_in2;
    logic [2:0]  alu_operation;
    logic [16:0] alu_out;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [16:0] res_data;
    logic [3:0]  res_tag;
    logic        res_illegal;
    logic [15:0] issued_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DEPTH(4), .TAG_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_in1       (cmd_in1),
        .cmd_in2       (cmd_in2),
        .cmd_op        (cmd_op),
        .cmd_tag       (cmd_tag),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .alu_operation (alu_operation),
        .alu_out       (alu_out),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_tag       (res_tag),
        .res_illegal   (res_illegal),
        .issued_cnt    (issued_cnt)
    );

    // Behavioural stand-in for the parent's combinational ALU.
    always_comb begin
        alu_out = '0;
        case (alu_operation)
            3'd0: alu_out = {1'b0, alu_in1} + {1'b0, alu_in2};
            3'd1: alu_out = {1'b0, alu_in1} - {1'b0, alu_in2};
            3'd2: alu_out = {1'b0, alu_in1 & alu_in2};
            3'd3: alu_out = {1'b0, alu_in1 | alu_in2};
            3'd4: alu_out = {1'b0, alu_in1 ^ alu_in2};
            default: alu_out = '0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".cmd_ready"},   {31'd0, cmd_ready},   32'd0);
        chk({nm, ".res_valid"},   {31'd0, res_valid},   32'd0);
        chk({nm, ".res_data"},    {15'd0, res_data},    32'd0);
        chk({nm, ".res_tag"},     {28'd0, res_tag},     32'd0);
        chk({nm, ".res_illegal"}, {31'd0, res_illegal}, 32'd0);
        chk({nm, ".issued_cnt"},  {16'd0, issued_cnt},  32'd0);
        chk({nm, ".alu_in1"},     {16'd0, alu_in1},     32'd0);
        chk({nm, ".alu_in2"},     {16'd0, alu_in2},     32'd0);
        chk({nm, ".alu_op"},      {29'd0, alu_operation}, 32'd7);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [3:0]  tag;
        logic [16:0] d;
        logic        ill;
    } vec_t;

    vec_t vt[9];

    initial begin
        int sent;
        int stale;

        vt[0] = '{16'hFFFF, 16'h0001, 3'd0, 4'd3,  17'h10000, 1'b0};
        vt[1] = '{16'h0003, 16'h0005, 3'd1, 4'd5,  17'h1FFFE, 1'b0};
        vt[2] = '{16'h1234, 16'h00FF, 3'd6, 4'd9,  17'h00000, 1'b1};
        vt[3] = '{16'h1234, 16'h4321, 3'd0, 4'd1,  17'h05555, 1'b0};
        vt[4] = '{16'hF0F0, 16'h0FF0, 3'd2, 4'd6,  17'h000F0, 1'b0};
        vt[5] = '{16'hAAAA, 16'h5555, 3'd4, 4'd2,  17'h0FFFF, 1'b0};
        vt[6] = '{16'h8000, 16'h0001, 3'd1, 4'd7,  17'h07FFF, 1'b0};
        vt[7] = '{16'hFFFF, 16'hFFFF, 3'd7, 4'd15, 17'h00000, 1'b1};
        vt[8] = '{16'h1200, 16'h0034, 3'd3, 4'd4,  17'h01234, 1'b0};

        // Reset: values observed while rst is still high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // Table: one command at a time, result one cycle after accept.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_in1 = vt[i].a; cmd_in2 = vt[i].b; cmd_op = vt[i].op; cmd_tag = vt[i].tag;
            chk($sformatf("v%0d.cmd_ready", i), {31'd0, cmd_ready}, 32'd1);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            chk($sformatf("v%0d.valid_early", i), {31'd0, res_valid}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d.res_valid", i), {31'd0, res_valid}, 32'd1);
            chk($sformatf("v%0d.res_data", i),  {15'd0, res_data},  {15'd0, vt[i].d});
            chk($sformatf("v%0d.res_tag", i),   {28'd0, res_tag},   {28'd0, vt[i].tag});
            chk($sformatf("v%0d.res_illegal", i), {31'd0, res_illegal}, {31'd0, vt[i].ill});
            chk($sformatf("v%0d.issued_cnt", i), {16'd0, issued_cnt}, i + 1);
        end
        @(posedge clk); #1;
        chk("table_drained", {31'd0, res_valid}, 32'd0);

        // Backpressure: stream 6 adds with res_ready low; only 5 fit.
        res_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            logic rdy;
            @(negedge clk);
            cmd_valid = (sent < 6);
            cmd_in1 = 16'(sent); cmd_in2 = 16'h0010; cmd_op = 3'd0; cmd_tag = 4'(sent);
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy && cmd_valid) sent++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp.accepted", sent, 32'd5);
        chk("bp.cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk("bp.hold_valid", {31'd0, res_valid}, 32'd1);
        chk("bp.hold_tag", {28'd0, res_tag}, 32'd0);
        @(negedge clk);
        chk("bp.stable_data", {15'd0, res_data}, 32'h10);
        chk("bp.stable_tag", {28'd0, res_tag}, 32'd0);
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp.r%0d.valid", k), {31'd0, res_valid}, 32'd1);
            chk($sformatf("bp.r%0d.tag", k),   {28'd0, res_tag},   k);
            chk($sformatf("bp.r%0d.data", k),  {15'd0, res_data},  32'h10 + k);
            @(negedge clk);
        end
        chk("bp.drained", {31'd0, res_valid}, 32'd0);
        chk("bp.issued_cnt", {16'd0, issued_cnt}, 32'd14);
        chk("bp.ready_back", {31'd0, cmd_ready}, 32'd1);

        // Full-rate logic-op stream: results on consecutive cycles.
        cmd_valid = 1'b1; cmd_in1 = 16'hF0F0; cmd_in2 = 16'h0FF0; cmd_op = 3'd2; cmd_tag = 4'd1;
        @(posedge clk);
        @(negedge clk);
        cmd_op = 3'd3; cmd_tag = 4'd2;
        @(posedge clk); #1;
        chk("fr.and", {15'd0, res_data}, 32'h000F0);
        @(negedge clk);
        cmd_op = 3'd4; cmd_tag = 4'd3;
        @(posedge clk); #1;
        chk("fr.or", {15'd0, res_data}, 32'h0FFF0);
        chk("fr.or_valid", {31'd0, res_valid}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("fr.xor", {15'd0, res_data}, 32'h0FF00);
        chk("fr.xor_tag", {28'd0, res_tag}, 32'd3);
        @(posedge clk); #1;

        // Reset with a held result and 3 queued commands.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_in1 = 16'h0100; cmd_in2 = 16'(i); cmd_op = 3'd0; cmd_tag = 4'(8 + i);
            @(posedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid.held", {31'd0, res_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (res_valid) stale++;
        end
        chk("mid.no_stale", stale, 32'd0);
        chk("mid.cnt_zero", {16'd0, issued_cnt}, 32'd0);
        chk("mid.ready", {31'd0, cmd_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
